// File: rtl/frame_sender.sv
// frame_sender: SPI master that streams a buffered LED frame out on sck/sdo, LSB first
module frame_sender #(
  parameter int CDEPTH      = 4,
  parameter int FRAME_ORDER = 10,
  parameter int SCK_HALF    = 4,
  parameter int GAP_CYCLES  = 2048
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [FRAME_ORDER-1:0] waddr,
  input  logic [3*CDEPTH-1:0]    wpix,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   sck,
  output logic                   sdo
);
  localparam int PW = 3*CDEPTH;
  localparam int HW = $clog2(SCK_HALF);
  localparam int GW = $clog2(GAP_CYCLES+1);
  localparam int BW = $clog2(PW);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, LO, HI, GAP, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] mem [2**FRAME_ORDER];
  logic [PW-1:0] rdata, shreg, shreg_n;
  logic [FRAME_ORDER-1:0] addr, addr_n, ram_addr;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic sck_n, sdo_n, busy_n, done_n;
  assign ram_addr = (state == IDLE) ? waddr : addr;
  // frame buffer: writes only while idle, synchronous read with one cycle latency
  always_ff @(posedge clk) begin
    if (we && state == IDLE) mem[ram_addr] <= wpix;
    rdata <= mem[ram_addr];
  end
  // state, counters and pin flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      hcnt  <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
      shreg <= '0;
      sck   <= 1'b0;
      sdo   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      hcnt  <= hcnt_n;
      bcnt  <= bcnt_n;
      gcnt  <= gcnt_n;
      shreg <= shreg_n;
      sck   <= sck_n;
      sdo   <= sdo_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end
  // next state; pins are decoded from the next state so they come straight off flops
  always_comb begin
    state_n = state;
    addr_n  = addr;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    shreg_n = shreg;
    case (state)
      IDLE: if (start) begin
        state_n = FETCH;
        addr_n  = '0;
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shreg_n = rdata;
        bcnt_n  = '0;
        hcnt_n  = '0;
        state_n = LO;
      end
      LO: begin
        hcnt_n  = (hcnt == HW'(SCK_HALF-1)) ? '0 : hcnt + 1'b1;
        state_n = (hcnt == HW'(SCK_HALF-1)) ? HI : LO;
      end
      HI: if (hcnt == HW'(SCK_HALF-1)) begin
        hcnt_n = '0;
        if (bcnt < BW'(PW-1)) begin
          shreg_n = shreg >> 1;
          bcnt_n  = bcnt + 1'b1;
          state_n = LO;
        end else if (&addr) begin
          gcnt_n  = '0;
          state_n = GAP;
        end else begin
          addr_n  = addr + 1'b1;
          state_n = FETCH;
        end
      end else hcnt_n = hcnt + 1'b1;
      GAP: begin
        gcnt_n  = gcnt + 1'b1;
        state_n = (gcnt == GW'(GAP_CYCLES-1)) ? DONE : GAP;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    sck_n  = (state_n == HI);
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    sdo_n  = (state_n == LO) ? shreg_n[0] :
             (state_n == HI || state_n == FETCH || state_n == LOAD) ? sdo : 1'b0;
  end
endmodule

// File: tb/tb_frame_sender.sv
// tb_frame_sender: directed checks of frame_sender bit stream, timing and ignored inputs
module tb_frame_sender;
  localparam int CD = 4, FO = 4, SH = 4, GAP = 40, PW = 3*CD, NPIX = 1 << FO;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, start = 1'b0;
  logic [FO-1:0] waddr = '0;
  logic [PW-1:0] wpix = '0;
  logic busy, done, sck, sdo;
  frame_sender #(.CDEPTH(CD), .FRAME_ORDER(FO), .SCK_HALF(SH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wpix(wpix),
    .start(start), .busy(busy), .done(done), .sck(sck), .sdo(sdo)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  int cyc = 0, rise_cnt = 0, done_cnt = 0, viol = 0, sdo_viol = 0, phase_len = 0;
  int busy_cyc = 0, first_rise = 0, last_rise = 0, done_cyc = 0;
  logic p_sck = 1'b0, p_sdo = 1'b0, p_busy = 1'b0;
  logic [PW-1:0] cap [NPIX];
  logic [PW-1:0] exp_pix [NPIX];
  // bus monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (sck !== p_sck) begin
      if (busy && phase_len < SH) viol++;
      phase_len = 1;
    end else phase_len++;
    if (p_sck && sck && sdo !== p_sdo) sdo_viol++;
    if (sck && !p_sck) begin
      if (rise_cnt == 0) first_rise = cyc;
      last_rise = cyc;
      if (rise_cnt < PW*NPIX) cap[rise_cnt/PW][rise_cnt%PW] = sdo;
      rise_cnt++;
    end
    if (busy && !p_busy) busy_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_sck = sck;
    p_sdo = sdo;
    p_busy = busy;
  end
  task automatic clear_mon();
    @(posedge clk);
    rise_cnt = 0; done_cnt = 0; viol = 0; sdo_viol = 0;
    for (int i = 0; i < NPIX; i++) cap[i] = 12'hFFF;
  endtask
  task automatic run_frame(input string tag, input bit poke);
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; we = 1'b0;
    for (int t = 0; t < 4000 && done_cnt == 0; t++) begin
      @(posedge clk);
      if (poke && t == 300) begin
        @(negedge clk); start = 1'b1; we = 1'b1; waddr = 4'd7; wpix = 12'hABC;
        @(negedge clk); start = 1'b0; we = 1'b0;
      end
    end
    check({tag, "_done_seen"}, int'(done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_rises"}, rise_cnt, PW*NPIX);
    check({tag, "_first_rise"}, first_rise - busy_cyc, 2 + SH);
    check({tag, "_gap"}, done_cyc - last_rise, SH + GAP);
    check({tag, "_phase_viol"}, viol, 0);
    check({tag, "_sdo_viol"}, sdo_viol, 0);
    for (int i = 0; i < NPIX; i++) check($sformatf("%s_pix%0d", tag, i), int'(cap[i]), int'(exp_pix[i]));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sck", int'(sck), 0);
    check("rst_sdo", int'(sdo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    clear_mon();
    repeat (100) @(negedge clk);
    check("idle_no_sck", rise_cnt, 0);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = FO'(i); wpix = (i == 0) ? 12'h123 : PW'((i*5) % 4096);
      exp_pix[i] = PW'((i*5) % 4096);
    end
    @(negedge clk);
    we = 1'b1; waddr = '0; wpix = '0;
    run_frame("f1", 1'b1);
    run_frame("f2", 1'b0);
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < 4000 && rise_cnt < 10*PW + 6; t++) @(posedge clk);
    check("mid_reached", int'(rise_cnt >= 10*PW + 6), 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_sck", int'(sck), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sdo", int'(sdo), 0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame("f3", 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_sender.md
Name: frame_sender

Overview:
- SPI master transmitter that streams one full LED frame into the matrix driver's SPI frame receiver.
- Holds a local 2**FRAME_ORDER x 3*CDEPTH frame buffer, loaded through a RAM-style write port.
- On a start pulse, shifts every pixel out on sck/sdo in address order, LSB first, matching the receiver's sampling rules.
- Used on the audio-processing FPGA side, and as the loopback source in system benches.

Parameters:
CDEPTH, 4, bits per colour channel; each pixel is 3*CDEPTH bits.
FRAME_ORDER, 10, frame holds 2**FRAME_ORDER pixels.
SCK_HALF, 4, clk cycles per sck half-period; legal values are 3 or more (receiver needs 2 sync flops plus 1 state cycle).
GAP_CYCLES, 2048, clk cycles sck is held low after the last bit; covers the receiver's copy phase.

Ports:
clk  in  1  board clock (40MHz)
reset  in  1  synchronous, active-high reset
we  in  1  buffer write enable; honoured only while busy=0
waddr  in  FRAME_ORDER  buffer write address
wpix  in  3*CDEPTH  buffer write data
start  in  1  begin sending a frame; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when frame and gap are complete
sck  out  1  SPI clock; idles low
sdo  out  1  SPI data, connected to the receiver's sdi; idles low

Behaviour:
- Reset: state=IDLE, sck=0, sdo=0, busy=0, done=0, pixel address=0, bit count=0, half-period counter=0, gap counter=0.
- Buffer contents are not cleared by reset.
- sck, sdo, busy and done are driven directly from flops, so there is no decode glitching on the pins.
- RAM: single port, synchronous read, 1-cycle latency.
  - Address mux: waddr in IDLE, internal pixel address otherwise.
  - In IDLE, we=1 writes wpix to buffer[waddr].
  - While busy, we is ignored and the write is dropped.
- States: IDLE, FETCH, LOAD, LO, HI, GAP, DONE.
  - IDLE: if start=1, go to FETCH with pixel address=0. start in any other state is ignored; it is not queued.
  - FETCH (1 cycle): RAM read issued.
  - LOAD (1 cycle): shift register <= RAM output; bit count=0.
  - LO (SCK_HALF cycles): sck=0, sdo=shreg[0]. sdo changes only on entry to LO, so it is stable for at least SCK_HALF cycles before the sck rise.
  - HI (SCK_HALF cycles): sck=1, sdo held.
  - Exit from HI:
    - If bit count < 3*CDEPTH-1: shreg >>= 1, bit count++, go to LO.
    - Else if pixel address is all ones: go to GAP.
    - Else: pixel address++, go to FETCH. sck stays low through FETCH/LOAD; a longer low phase is legal.
  - GAP (GAP_CYCLES cycles): sck=0, sdo=0.
  - DONE (1 cycle): done=1, then IDLE.
- Bit order: pixel 0 first, address ascending; within a pixel bit 0 first. After 3*CDEPTH rising edges the receiver holds the pixel unchanged.
- Edge counts and timing:
  - Exactly 3*CDEPTH * 2**FRAME_ORDER sck rising edges per frame.
  - Per-pixel cost is 2 + 2*SCK_HALF*3*CDEPTH cycles (98 at defaults).
  - First sck rise occurs 2+SCK_HALF cycles after the IDLE->FETCH edge.
- busy: asserted FETCH through DONE inclusive; deasserted in the same cycle IDLE is re-entered.
- Pixel address wraps to 0 only via the IDLE->FETCH transition; it never increments past all ones.
- Reset mid-frame: outputs return to reset values on the next clk edge, and the partial frame is abandoned. The receiver is then responsible for recovery, since its state is not reset by this block.
- Simultaneous start and we in IDLE: the write is performed and start is accepted in the same cycle. FETCH reads the new data if waddr=0.
- Counter widths: half-period counter is $clog2(SCK_HALF) bits; gap counter is $clog2(GAP_CYCLES+1) bits.

Test Plan:
- Reset: hold reset 3 cycles, then release -> sck=0, sdo=0, busy=0, done=0. No sck edge for 100 cycles without start.
- Single frame: load buffer[i]=i*5 mod 4096 for all 1024 addresses, pulse start.
  - 12288 sck rises observed.
  - Bits captured on sck rise, LSB first, reassemble to i*5 mod 4096.
  - done pulses exactly once, after the gap; busy falls with it.
- Timing at defaults: first sck rise 6 cycles after start accepted; every high and low phase is at least 4 cycles; sdo never changes while sck=1; no sck rise during the final 2048 gap cycles.
- Ignored inputs: start pulsed mid-frame -> no restart, edge count still 12288. we=1 at waddr=7 with 0xABC while busy -> next frame still sends the old buffer[7].
- Reset mid-frame: assert reset at pixel 300, bit 5 -> next cycle sck=0, busy=0. A fresh start sends the full frame from pixel 0.
- Loopback: connect sck/sdo to the matrix driver's SPI frame receiver, send the frame -> receiver rdone pulses once, and its buffer matches the sender buffer at all 1024 addresses.
